// File: rtl/sc_config_pkg.sv
// Shared register-map offsets, CTRL bit positions and byte-lane merge helper
// for the scan-converter config register bank.
package sc_config_pkg;

  // Offsets are relative to NUM_STATUS, the first address after the status words.
  localparam int unsigned CTRL_OFS        = 0;
  localparam int unsigned IRQ_STAT_OFS    = 1;
  localparam int unsigned IRQ_MASK_OFS    = 2;
  localparam int unsigned SHADOW_BASE_OFS = 3;

  localparam int unsigned CTRL_COMMIT_BIT    = 0;
  localparam int unsigned CTRL_IMMEDIATE_BIT = 1;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] m;
    for (int unsigned i = 0; i < 4; i++) begin
      m[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/sc_config_shadow.sv
// Shadow/active config word pairs: byte-lane writes land in shadow, commit_i
// copies every shadow word to active. shadow_o exists only with SC_CONFIG_READBACK_EN.
module sc_config_shadow
  import sc_config_pkg::*;
#(
  parameter int unsigned NUM_CONFIG = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_CONFIG-1:0]     wr_sel_i,
  input  logic [31:0]               wdata_i,
  input  logic [3:0]                be_i,
  input  logic                      commit_i,
`ifdef SC_CONFIG_READBACK_EN
  output logic [32*NUM_CONFIG-1:0]  shadow_o,
`endif
  output logic [32*NUM_CONFIG-1:0]  active_o
);

  logic [32*NUM_CONFIG-1:0] shadow_q, shadow_d;
  logic [32*NUM_CONFIG-1:0] active_q;

  always_comb begin
    shadow_d = shadow_q;
    for (int unsigned k = 0; k < NUM_CONFIG; k++) begin
      if (wr_sel_i[k]) begin
        shadow_d[32*k +: 32] = be_merge(shadow_q[32*k +: 32], wdata_i, be_i);
      end
    end
  end

  // Active takes the pre-write shadow, so a write colliding with a commit waits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      if (commit_i) active_q <= shadow_q;
    end
  end

`ifdef SC_CONFIG_READBACK_EN
  assign shadow_o = shadow_q;
`endif
  assign active_o = active_q;

endmodule

// File: rtl/sc_config_regbank.sv
// Avalon-MM config/status register bank with frame-synchronous config commit
// and maskable status-change interrupt. Optional: SC_CONFIG_READBACK_EN.
module sc_config_regbank
  import sc_config_pkg::*;
#(
  parameter int unsigned NUM_STATUS = 2,
  parameter int unsigned NUM_CONFIG = 8,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDR_W-1:0]         avalon_s_address,
  input  logic [31:0]               avalon_s_writedata,
  input  logic [3:0]                avalon_s_byteenable,
  input  logic                      avalon_s_chipselect,
  input  logic                      avalon_s_write,
  input  logic                      avalon_s_read,
  output logic [31:0]               avalon_s_readdata,
  output logic                      avalon_s_readdatavalid,
  output logic                      avalon_s_waitrequest_n,
  input  logic                      vsync_i,
  input  logic [32*NUM_STATUS-1:0]  status_i,
  output logic [32*NUM_CONFIG-1:0]  config_o,
  output logic                      commit_pending_o,
  output logic                      irq_o
);

  localparam int unsigned S = NUM_STATUS;
  localparam logic [ADDR_W:0] A_CTRL  = (ADDR_W+1)'(S + CTRL_OFS);
  localparam logic [ADDR_W:0] A_ISTAT = (ADDR_W+1)'(S + IRQ_STAT_OFS);
  localparam logic [ADDR_W:0] A_IMASK = (ADDR_W+1)'(S + IRQ_MASK_OFS);
  localparam logic [ADDR_W:0] A_SHAD  = (ADDR_W+1)'(S + SHADOW_BASE_OFS);

  logic [ADDR_W:0]         addr_x;
  logic                    wr_en, rd_en, wr_ctrl, wr_istat, wr_imask, commit;
  logic [NUM_CONFIG-1:0]   sh_sel;
  logic [S-1:0]            chg, clr;
  logic [15:0]             w1c16;
  logic [31:0]             rd_mux;

  logic                    pending_q, pending_d, imm_q, irq_q, rvalid_q;
  logic [S-1:0]            irq_stat_q, irq_stat_d;
  logic [31:0]             irq_mask_q, rdata_q;
  logic [32*S-1:0]         status_prev_q;
  logic [32*NUM_CONFIG-1:0] active_w;
`ifdef SC_CONFIG_READBACK_EN
  logic [32*NUM_CONFIG-1:0] shadow_w;
`endif

  assign addr_x   = {1'b0, avalon_s_address};
  assign wr_en    = avalon_s_chipselect & avalon_s_write;
  assign rd_en    = avalon_s_chipselect & avalon_s_read;
  assign wr_ctrl  = wr_en && (addr_x == A_CTRL);
  assign wr_istat = wr_en && (addr_x == A_ISTAT);
  assign wr_imask = wr_en && (addr_x == A_IMASK);
  assign commit   = pending_q & (vsync_i | imm_q);

  // W1C is accepted on lanes 0 and 1 only; a simultaneous new change still sets.
  assign w1c16      = avalon_s_writedata[15:0] &
                      {{8{avalon_s_byteenable[1]}}, {8{avalon_s_byteenable[0]}}};
  assign clr        = wr_istat ? w1c16[S-1:0] : '0;
  assign irq_stat_d = (irq_stat_q & ~clr) | chg;
  assign pending_d  = (pending_q & ~commit) | (wr_ctrl & avalon_s_writedata[CTRL_COMMIT_BIT]);

  always_comb begin
    chg = '0;
    for (int unsigned k = 0; k < S; k++) begin
      chg[k] = status_i[32*k +: 32] != status_prev_q[32*k +: 32];
    end
    sh_sel = '0;
    for (int unsigned k = 0; k < NUM_CONFIG; k++) begin
      sh_sel[k] = wr_en && (addr_x == A_SHAD + (ADDR_W+1)'(k));
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned k = 0; k < S; k++) begin
      if (addr_x == (ADDR_W+1)'(k)) rd_mux = status_i[32*k +: 32];
    end
    if (addr_x == A_CTRL) begin
      rd_mux[CTRL_COMMIT_BIT]    = pending_q;
      rd_mux[CTRL_IMMEDIATE_BIT] = imm_q;
    end
    if (addr_x == A_ISTAT) rd_mux[S-1:0] = irq_stat_q;
    if (addr_x == A_IMASK) rd_mux = irq_mask_q;
`ifdef SC_CONFIG_READBACK_EN
    for (int unsigned k = 0; k < NUM_CONFIG; k++) begin
      if (addr_x == A_SHAD + (ADDR_W+1)'(k)) rd_mux = shadow_w[32*k +: 32];
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q     <= 1'b0;
      imm_q         <= 1'b0;
      irq_stat_q    <= '0;
      irq_mask_q    <= '0;
      status_prev_q <= '0;
      rdata_q       <= '0;
      rvalid_q      <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      if (wr_ctrl) imm_q <= avalon_s_writedata[CTRL_IMMEDIATE_BIT];
      irq_stat_q    <= irq_stat_d;
      if (wr_imask) irq_mask_q <= be_merge(irq_mask_q, avalon_s_writedata, avalon_s_byteenable);
      status_prev_q <= status_i;
      rvalid_q      <= rd_en;
      if (rd_en) rdata_q <= rd_mux;
      irq_q         <= |(irq_stat_q & irq_mask_q[S-1:0]);
    end
  end

  sc_config_shadow #(
    .NUM_CONFIG (NUM_CONFIG)
  ) u_shadow (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_sel_i (sh_sel),
    .wdata_i  (avalon_s_writedata),
    .be_i     (avalon_s_byteenable),
    .commit_i (commit),
`ifdef SC_CONFIG_READBACK_EN
    .shadow_o (shadow_w),
`endif
    .active_o (active_w)
  );

  assign config_o               = active_w;
  assign commit_pending_o       = pending_q;
  assign irq_o                  = irq_q;
  assign avalon_s_readdata      = rdata_q;
  assign avalon_s_readdatavalid = rvalid_q;
  assign avalon_s_waitrequest_n = 1'b1;

endmodule

// File: tb/tb_sc_config_regbank.sv
// Directed + randomized bench for sc_config_regbank against an array-based
// behavioural model of the register map; honours SC_CONFIG_READBACK_EN.
module tb_sc_config_regbank;

  localparam int NS = 2;
  localparam int NC = 8;
  localparam int AW = 6;
`ifdef SC_CONFIG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     addr;
  logic [31:0]       wdata;
  logic [3:0]        be;
  logic              cs, wr, rd, vs;
  logic [32*NS-1:0]  st;
  logic [31:0]       rdata;
  logic              rvalid, wreq_n, pending, irq;
  logic [32*NC-1:0]  cfg;

  always #5 clk = ~clk;

  sc_config_regbank #(
    .NUM_STATUS (NS),
    .NUM_CONFIG (NC),
    .ADDR_W     (AW)
  ) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .avalon_s_address       (addr),
    .avalon_s_writedata     (wdata),
    .avalon_s_byteenable    (be),
    .avalon_s_chipselect    (cs),
    .avalon_s_write         (wr),
    .avalon_s_read          (rd),
    .avalon_s_readdata      (rdata),
    .avalon_s_readdatavalid (rvalid),
    .avalon_s_waitrequest_n (wreq_n),
    .vsync_i                (vs),
    .status_i               (st),
    .config_o               (cfg),
    .commit_pending_o       (pending),
    .irq_o                  (irq)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0]      m_shadow [NC];
  logic [31:0]      m_active [NC];
  logic [31:0]      m_mask, m_rdata;
  logic             m_pending, m_imm, m_rvalid, m_irq;
  logic [NS-1:0]    m_stat;
  logic [32*NS-1:0] m_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      m_shadow[k] = '0;
      m_active[k] = '0;
    end
    m_mask = '0; m_rdata = '0; m_pending = 1'b0; m_imm = 1'b0;
    m_rvalid = 1'b0; m_irq = 1'b0; m_stat = '0; m_prev = '0;
  endtask

  // One clock edge worth of register-map semantics, using the inputs seen at the edge.
  task automatic model_step();
    int a;
    logic [31:0] rv;
    if (rst) begin
      model_reset();
      return;
    end
    a  = int'(addr);
    rv = '0;
    if (a < NS)                              rv = st[32*a +: 32];
    else if (a == NS)                        rv = {30'd0, m_imm, m_pending};
    else if (a == NS + 1)                    rv = 32'(m_stat);
    else if (a == NS + 2)                    rv = m_mask;
    else if (a >= NS + 3 && a < NS + 3 + NC) rv = RB ? m_shadow[a-NS-3] : 32'd0;

    m_irq = |(m_stat & m_mask[NS-1:0]);
    if (m_pending && (vs || m_imm)) begin
      for (int k = 0; k < NC; k++) m_active[k] = m_shadow[k];
      m_pending = 1'b0;
    end
    if (cs && wr) begin
      if (a == NS) begin
        if (wdata[0]) m_pending = 1'b1;
        m_imm = wdata[1];
      end
      if (a == NS + 1)
        for (int b = 0; b < NS; b++) if (wdata[b] && be[b/8]) m_stat[b] = 1'b0;
      if (a == NS + 2)
        for (int i = 0; i < 4; i++) if (be[i]) m_mask[8*i +: 8] = wdata[8*i +: 8];
      if (a >= NS + 3 && a < NS + 3 + NC)
        for (int i = 0; i < 4; i++) if (be[i]) m_shadow[a-NS-3][8*i +: 8] = wdata[8*i +: 8];
    end
    for (int k = 0; k < NS; k++)
      if (st[32*k +: 32] != m_prev[32*k +: 32]) m_stat[k] = 1'b1;
    m_prev   = st;
    m_rvalid = cs && rd;
    if (cs && rd) m_rdata = rv;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < NC; k++) chk($sformatf("config%0d", k), cfg[32*k +: 32], m_active[k]);
    chk("pending", 32'(pending), 32'(m_pending));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("rvalid", 32'(rvalid), 32'(m_rvalid));
    chk("rdata", rdata, m_rdata);
    chk("waitreq_n", 32'(wreq_n), 32'd1);
  endtask

  task automatic idle();
    cs = 1'b0; wr = 1'b0; rd = 1'b0; vs = 1'b0; be = 4'hF; wdata = '0; addr = '0;
  endtask

  task automatic wr_op(input int a, input logic [31:0] d, input logic [3:0] b);
    idle();
    addr = AW'(a); wdata = d; be = b; cs = 1'b1; wr = 1'b1;
    tick();
  endtask

  task automatic rd_op(input int a);
    idle();
    addr = AW'(a); cs = 1'b1; rd = 1'b1;
    tick();
  endtask

  initial begin
    model_reset();
    idle();
    st  = '0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_config0", cfg[31:0], 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;

    // Byte-lane shadow write, commit on vsync
    wr_op(NS + 3, 32'h12345678, 4'b0011);
    wr_op(NS, 32'h1, 4'hF);
    chk("commit_req_pending", 32'(pending), 32'd1);
    idle(); vs = 1'b1; tick();
    chk("vsync_commit_w0", cfg[31:0], 32'h00005678);
    chk("vsync_commit_pending", 32'(pending), 32'd0);

    // No vsync for 1000 cycles: nothing applies
    wr_op(NS + 3, 32'h0BADF00D, 4'hF);
    wr_op(NS, 32'h1, 4'hF);
    idle();
    for (int i = 0; i < 1000; i++) tick();
    chk("hold_pending", 32'(pending), 32'd1);
    chk("hold_w0", cfg[31:0], 32'h00005678);
    idle(); vs = 1'b1; tick();
    chk("late_commit_w0", cfg[31:0], 32'h0BADF00D);

    // IMMEDIATE mode: two edges after the COMMIT write
    wr_op(NS, 32'h2, 4'hF);
    wr_op(NS + 4, 32'h000000A5, 4'hF);
    wr_op(NS, 32'h3, 4'hF);
    chk("imm_pending_first", 32'(pending), 32'd1);
    chk("imm_w1_not_yet", cfg[63:32], 32'd0);
    idle(); tick();
    chk("imm_w1", cfg[63:32], 32'h000000A5);
    wr_op(NS, 32'h0, 4'hF);

    // Status change interrupt, W1C, collision keeps bit
    wr_op(NS + 2, 32'h1, 4'hF);
    idle(); st[31:0] = 32'h1; tick();
    tick();
    chk("irq_set", 32'(irq), 32'd1);
    wr_op(NS + 1, 32'h1, 4'hF);
    idle(); tick();
    chk("irq_clr", 32'(irq), 32'd0);
    st[31:0] = 32'h2;
    wr_op(NS + 1, 32'h1, 4'hF);
    rd_op(NS + 1);
    chk("w1c_collision", rdata, 32'h1);

    // Back-to-back reads
    idle(); st[31:0] = 32'hCAFE0001; tick();
    rd_op(0);
    chk("b2b_status0", rdata, 32'hCAFE0001);
    chk("b2b_v0", 32'(rvalid), 32'd1);
    rd_op(NS);
    chk("b2b_ctrl", rdata, 32'd0);
    chk("b2b_v1", 32'(rvalid), 32'd1);
    rd_op(60);
    chk("b2b_unused", rdata, 32'd0);
    chk("b2b_v2", 32'(rvalid), 32'd1);

    // Shadow readback depends on build option
    wr_op(NS + 3, 32'hFFFFFFFF, 4'hF);
    rd_op(NS + 3);
    chk("shadow_readback", rdata, RB ? 32'hFFFFFFFF : 32'd0);

    // Read and write in the same cycle return the old value
    idle(); addr = AW'(NS + 2); wdata = 32'hF0F0F0F0; cs = 1'b1; wr = 1'b1; rd = 1'b1; tick();
    chk("rw_same_old", rdata, 32'h1);
    rd_op(NS + 2);
    chk("rw_same_new", rdata, 32'hF0F0F0F0);

    // COMMIT write together with vsync defers to next vsync
    idle(); addr = AW'(NS); wdata = 32'h1; cs = 1'b1; wr = 1'b1; vs = 1'b1; tick();
    chk("commit_vsync_pending", 32'(pending), 32'd1);
    chk("commit_vsync_w0", cfg[31:0], 32'h0BADF00D);
    idle(); vs = 1'b1; tick();
    chk("commit_next_vsync_w0", cfg[31:0], 32'hFFFFFFFF);

    // Reset mid-operation drops pending and in-flight readdatavalid
    wr_op(NS, 32'h1, 4'hF);
    rd_op(0);
    idle(); rst = 1'b1; tick();
    chk("midrst_pending", 32'(pending), 32'd0);
    chk("midrst_rvalid", 32'(rvalid), 32'd0);
    chk("midrst_w0", cfg[31:0], 32'd0);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int w;
      idle();
      cs = ($urandom_range(0, 3) != 0);
      wr = $urandom_range(0, 1) == 1;
      rd = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) != 0) addr = AW'($urandom_range(0, NS + 2 + NC));
      else                           addr = AW'($urandom_range(0, (1 << AW) - 1));
      wdata = $urandom;
      be    = 4'($urandom);
      vs    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) begin
        w = $urandom_range(0, NS - 1);
        st[32*w +: 32] = $urandom;
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_config_regbank.md
# sc_config_regbank

Parametrised Avalon-MM register bank for the scan converter. It carries a configurable number of status inputs and config outputs. Config writes land in shadow registers and are committed to the active outputs at a frame boundary, so video parameters never change mid-frame. Status inputs raise a maskable change interrupt. It sits between the Nios II Avalon interconnect and the scan-converter pipeline.

## Interface
- NUM_STATUS, default 2, number of 32-bit status words; range 1..16
- NUM_CONFIG, default 8, number of 32-bit config words; range 1..32
- ADDR_W, default 6, Avalon word-address width; must satisfy 2^ADDR_W ≥ NUM_STATUS+3+NUM_CONFIG
- clk_i  in  1  single clock
- rst_i  in  1  reset, synchronous and active-high
- avalon_s_address  in  ADDR_W  word address
- avalon_s_writedata  in  32  write data
- avalon_s_byteenable  in  4  byte lanes
- avalon_s_chipselect / avalon_s_write / avalon_s_read  in  1 each  Avalon strobes
- avalon_s_readdata  out  32  read data, valid with readdatavalid
- avalon_s_readdatavalid  out  1  one-cycle pulse, fixed read latency 1
- avalon_s_waitrequest_n  out  1  tied 1
- vsync_i  in  1  one-cycle frame-boundary strobe from the pipeline
- status_i  in  32*NUM_STATUS  status words, word k at [32k+31:32k]
- config_o  out  32*NUM_CONFIG  active config words, same packing
- commit_pending_o  out  1  commit requested, not yet applied
- irq_o  out  1  |(irq_stat & irq_mask)

## Operation
- Address map (S = NUM_STATUS):
  - 0..S-1: STATUS, read-only.
  - S: CTRL.
  - S+1: IRQ_STAT, write-1-to-clear.
  - S+2: IRQ_MASK, read/write.
  - S+3..S+2+NUM_CONFIG: SHADOW[k].
  - Other addresses: read 0, writes ignored.
- Writes to SHADOW and IRQ_MASK honour byteenable per lane.
- CTRL fields:
  - bit0 COMMIT (write 1 sets pending; write 0 has no effect).
  - bit1 IMMEDIATE, stored.
  - bit0 reads back as pending.
- Commit:
  - When pending=1 and (vsync_i=1 or IMMEDIATE=1), all SHADOW words copy to config_o in the same cycle and pending clears.
  - config_o changes only on a commit, or on reset to 0.
- Status change detection:
  - status_prev is registered each cycle.
  - IRQ_STAT[k] sets when status word k differs from status_prev word k.
  - IRQ_STAT bits ≥ S are 0.
- IRQ_STAT clears only by writing 1 to the bit, on lane 0 or lane 1.
- Read:
  - The address is captured on chipselect&read.
  - Registered readdata and readdatavalid appear the next cycle.
- Reset values: config_o, SHADOW, CTRL, IRQ_STAT, IRQ_MASK, status_prev, readdata, readdatavalid, irq_o, commit_pending_o all 0.
- Boundary conditions:
  - COMMIT write in the same cycle as vsync_i: pending sets; the commit happens on the next vsync (or the next cycle if IMMEDIATE was already 1).
  - SHADOW write in the same cycle as a commit: config_o takes the pre-write shadow value; the new value waits for the next commit.
  - Status change in the same cycle as a W1C on the same bit: set wins.
  - Read and write in the same cycle: both are performed; the read returns the pre-write value.
  - Back-to-back reads are supported, one per cycle.
  - rst_i mid-operation drops pending and any in-flight readdatavalid.

## Timing
- Write takes effect on registers at the clock edge where chipselect&write is sampled.
- Read latency is exactly 1 cycle; waitrequest is never asserted.
- Commit to config_o: the edge on which vsync_i is sampled with pending=1.
  - IMMEDIATE mode: config_o updates 2 edges after the COMMIT write edge (pending is visible first).
- Status change to IRQ_STAT set: 1 edge after status_i changes.
- irq_o is registered: 1 further edge.

## Configuration
- SC_CONFIG_READBACK_EN:
  - Defined: SHADOW[k] addresses read back the shadow contents.
  - Undefined: they read 0 and the readback mux excludes them, saving logic.
- STATUS, CTRL, IRQ_STAT and IRQ_MASK are always readable.

## Structure
- Shared package sc_config_pkg holds:
  - register offset constants CTRL_OFS=0, IRQ_STAT_OFS=1, IRQ_MASK_OFS=2, SHADOW_BASE_OFS=3, all relative to NUM_STATUS;
  - CTRL bit indices;
  - a function be_merge(old, new, be) returning the byte-lane merge.
- One sub-module, sc_config_shadow: a NUM_CONFIG-word shadow/active register pair with byteenable write and commit input.

## Test plan
- Write SHADOW[0]=0x12345678 with be=4'b0011, then COMMIT, then pulse vsync_i -> config_o word0=0x00005678 on the vsync edge; commit_pending_o goes 1→0.
- Write COMMIT, then hold vsync_i low for 1000 cycles -> config_o unchanged, commit_pending_o=1; then one vsync_i pulse -> commit.
- Set CTRL=0x2 (IMMEDIATE), write SHADOW[1]=0xA5, write CTRL=0x3 -> config_o word1=0xA5 two edges after the write.
- IRQ_MASK=1, toggle status_i word0 -> IRQ_STAT=1 and irq_o=1; write IRQ_STAT=1 -> irq_o returns to 0; a change colliding with the W1C keeps the bit set.
- Back-to-back reads of STATUS0, CTRL and an unused address -> three consecutive readdatavalid pulses, data = status, pending/IMMEDIATE bits, 0.
- With SC_CONFIG_READBACK_EN undefined, read SHADOW[0] after a write of 0xFFFFFFFF -> 0; with it defined -> 0xFFFFFFFF.
